axi4_burst_slave: RTL

- Synthesizable AXI4 slave responder with on-chip storage: the far end of the ISP's 128-bit AXI master port.
- Accepts INCR bursts on the read and write channels and serves them from an internal word array.
- Replaces the behavioural DRAM model in gate-level and emulation benches; also serves as a scratch memory for later blocks.
- Handles one transaction at a time. Write wins when AW and AR are presented together.

---
 rtl/axi4_slave_pkg.sv | 21 ++
 rtl/axi4_burst_slave_if.sv | 57 +++++
 rtl/axi_slave_mem.sv | 24 ++
 rtl/axi4_burst_slave.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/axi4_slave_pkg.sv
// Shared constants, FSM state type and burst-legality helper for the AXI4 burst slave.
package axi4_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_16B    = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_DATA
    } state_e;

    // Only full-width INCR bursts are served; anything else answers SLVERR.
    function automatic logic burst_unsupported(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_16B) || (burst != BURST_INCR);
    endfunction

endpackage

// File: rtl/axi4_burst_slave_if.sv
// AXI4 bus bundle (AW/W/B/AR/R channels) between the ISP master and the burst slave.
interface axi4_burst_slave_if;
    logic [3:0]   awid_s_inf;
    logic [31:0]  awaddr_s_inf;
    logic [2:0]   awsize_s_inf;
    logic [1:0]   awburst_s_inf;
    logic [7:0]   awlen_s_inf;
    logic         awvalid_s_inf;
    logic         awready_s_inf;
    logic [127:0] wdata_s_inf;
    logic         wlast_s_inf;
    logic         wvalid_s_inf;
    logic         wready_s_inf;
    logic [3:0]   bid_s_inf;
    logic [1:0]   bresp_s_inf;
    logic         bvalid_s_inf;
    logic         bready_s_inf;
    logic [3:0]   arid_s_inf;
    logic [31:0]  araddr_s_inf;
    logic [7:0]   arlen_s_inf;
    logic [2:0]   arsize_s_inf;
    logic [1:0]   arburst_s_inf;
    logic         arvalid_s_inf;
    logic         arready_s_inf;
    logic [3:0]   rid_s_inf;
    logic [127:0] rdata_s_inf;
    logic [1:0]   rresp_s_inf;
    logic         rlast_s_inf;
    logic         rvalid_s_inf;
    logic         rready_s_inf;

    modport slave (
        input  awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
        output awready_s_inf,
        input  wdata_s_inf, wlast_s_inf, wvalid_s_inf,
        output wready_s_inf,
        output bid_s_inf, bresp_s_inf, bvalid_s_inf,
        input  bready_s_inf,
        input  arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
        output arready_s_inf,
        output rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
        input  rready_s_inf
    );

    modport master (
        output awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
        input  awready_s_inf,
        output wdata_s_inf, wlast_s_inf, wvalid_s_inf,
        input  wready_s_inf,
        input  bid_s_inf, bresp_s_inf, bvalid_s_inf,
        output bready_s_inf,
        output arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
        input  arready_s_inf,
        input  rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
        output rready_s_inf
    );
endinterface

// File: rtl/axi_slave_mem.sv
// DEPTH x 128-bit word store: synchronous write, combinational read. Contents survive reset.
module axi_slave_mem #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [127:0]     wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [127:0]     rdata_o
);

    logic [127:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/axi4_burst_slave.sv
// AXI4 INCR-burst slave serving one transaction at a time from an internal word array.
module axi4_burst_slave
    import axi4_slave_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    axi4_burst_slave_if.slave  bus
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         beat_q, beat_d;
    logic               err_q, err_d;
    logic               rvalid_q, rvalid_d;
    logic               rlast_q, rlast_d;
    logic [127:0]       rdata_q, rdata_d;
    logic [3:0]         rid_q, rid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic               bvalid_q, bvalid_d;
    logic [3:0]         bid_q, bid_d;
    logic [1:0]         bresp_q, bresp_d;

    logic [IDX_W-1:0]   aw_idx, ar_idx, idx_inc, mem_ridx;
    logic               aw_unsup, ar_unsup, w_err, mem_we;
    logic [127:0]       mem_rdata;
    logic               unused_addr_bits;

    assign aw_idx   = bus.awaddr_s_inf[IDX_W+3:4];
    assign ar_idx   = bus.araddr_s_inf[IDX_W+3:4];
    assign idx_inc  = idx_q + IDX_W'(1);
    assign aw_unsup = burst_unsupported(bus.awsize_s_inf, bus.awburst_s_inf);
    assign ar_unsup = burst_unsupported(bus.arsize_s_inf, bus.arburst_s_inf);
    assign unused_addr_bits = ^{bus.awaddr_s_inf[31:IDX_W+4], bus.awaddr_s_inf[3:0],
                                bus.araddr_s_inf[31:IDX_W+4], bus.araddr_s_inf[3:0]};

    axi_slave_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .widx_i  (idx_q),
        .wdata_i (bus.wdata_s_inf),
        .ridx_i  (mem_ridx),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            rresp_q  <= RESP_OKAY;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
            rresp_q  <= rresp_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        beat_d   = beat_q;
        err_d    = err_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        mem_we   = 1'b0;
        mem_ridx = idx_inc;
        w_err    = err_q;

        case (state_q)
            IDLE: begin
                // Address the array with the incoming AR so beat 0 is ready one cycle later.
                mem_ridx = ar_idx;
                if (bus.awvalid_s_inf) begin
                    idx_d   = aw_idx;
                    len_d   = bus.awlen_s_inf;
                    beat_d  = '0;
                    err_d   = aw_unsup;
                    bid_d   = bus.awid_s_inf;
                    state_d = WR_DATA;
                end else if (bus.arvalid_s_inf) begin
                    idx_d    = ar_idx;
                    len_d    = bus.arlen_s_inf;
                    beat_d   = '0;
                    err_d    = ar_unsup;
                    rid_d    = bus.arid_s_inf;
                    rvalid_d = 1'b1;
                    rdata_d  = ar_unsup ? '0 : mem_rdata;
                    rlast_d  = (bus.arlen_s_inf == 8'd0);
                    rresp_d  = ar_unsup ? RESP_SLVERR : RESP_OKAY;
                    state_d  = RD_DATA;
                end
            end
            WR_DATA: begin
                if (bus.wvalid_s_inf) begin
                    mem_we = !err_q && rst_n;
                    w_err  = err_q | (bus.wlast_s_inf != (beat_q == len_q));
                    err_d  = w_err;
                    idx_d  = idx_inc;
                    beat_d = beat_q + 8'd1;
                    // Beat count, not wlast, closes the burst.
                    if (beat_q == len_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = w_err ? RESP_SLVERR : RESP_OKAY;
                        state_d  = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bus.bready_s_inf) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD_DATA: begin
                if (bus.rready_s_inf) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        idx_d   = idx_inc;
                        beat_d  = beat_q + 8'd1;
                        rdata_d = err_q ? '0 : mem_rdata;
                        rlast_d = ((beat_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.awready_s_inf = (state_q == IDLE);
    assign bus.arready_s_inf = (state_q == IDLE) && !bus.awvalid_s_inf;
    assign bus.wready_s_inf  = (state_q == WR_DATA);
    assign bus.bvalid_s_inf  = bvalid_q;
    assign bus.bid_s_inf     = bid_q;
    assign bus.bresp_s_inf   = bresp_q;
    assign bus.rvalid_s_inf  = rvalid_q;
    assign bus.rlast_s_inf   = rlast_q;
    assign bus.rdata_s_inf   = rdata_q;
    assign bus.rid_s_inf     = rid_q;
    assign bus.rresp_s_inf   = rresp_q;

endmodule
